// File: rtl/dino_motion.sv
// Dinosaur motion controller: run/jump/duck state, parabolic jump height,
// leg animation, and a two-stage sprite ROM lookup pipeline producing px.
module dino_motion #(
  parameter int X0      = 80,
  parameter int GROUND  = 402,
  parameter int SPR_W   = 82,
  parameter int SPR_H   = 88,
  parameter int DUCK_H  = 52,
  parameter int JUMP_T  = 40,
  parameter int LEG_DIV = 6
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_frame_tick,
  input  logic       i_game_status,
  input  logic       i_start,
  input  logic       i_button_jump,
  input  logic       i_button_duck,
  input  logic [8:0] i_row_addr,
  input  logic [9:0] i_col_addr,
  output logic [6:0] o_rom_addr_row,
  output logic [6:0] o_rom_addr_col,
  output logic [1:0] o_rom_sel,
  input  logic       i_rom_bit,
  output logic       o_px,
  output logic [9:0] o_dino_top,
  output logic [9:0] o_dino_bottom,
  output logic [1:0] o_state
);

  typedef enum logic [1:0] {S_RUN = 2'd0, S_JUMP = 2'd1, S_DUCK = 2'd2} state_t;

  state_t     r_state, w_state_nx;
  logic [6:0] r_t, w_t_nx;
  logic [7:0] w_t_step;
  logic [7:0] r_leg_cnt, w_leg_cnt_nx;
  logic       r_leg, w_leg_nx;
  logic       w_run, w_restart;

  assign w_run     = i_frame_tick & i_game_status;
  assign w_restart = i_frame_tick & ~i_game_status & i_start;
  assign w_t_step  = {1'b0, r_t} + (i_button_duck ? 8'd2 : 8'd1);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= S_RUN;
      r_t       <= '0;
      r_leg_cnt <= '0;
      r_leg     <= 1'b0;
    end else begin
      r_state   <= w_state_nx;
      r_t       <= w_t_nx;
      r_leg_cnt <= w_leg_cnt_nx;
      r_leg     <= w_leg_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_t_nx     = r_t;
    if (w_restart) begin
      w_state_nx = S_RUN;
      w_t_nx     = '0;
    end else if (w_run) begin
      case (r_state)
        S_RUN: begin
          if (i_button_jump) begin
            w_state_nx = S_JUMP;
            w_t_nx     = 7'd1;
          end else if (i_button_duck) begin
            w_state_nx = S_DUCK;
          end
        end
        S_JUMP: begin
          // Landing always returns to RUN; a held duck takes effect next tick.
          if (w_t_step >= 8'(JUMP_T)) begin
            w_state_nx = S_RUN;
            w_t_nx     = '0;
          end else begin
            w_t_nx = w_t_step[6:0];
          end
        end
        S_DUCK: if (!i_button_duck) w_state_nx = S_RUN;
        default: begin
          w_state_nx = S_RUN;
          w_t_nx     = '0;
        end
      endcase
    end
  end

  always_comb begin
    w_leg_cnt_nx = r_leg_cnt;
    w_leg_nx     = r_leg;
    if (w_restart) begin
      w_leg_cnt_nx = '0;
      w_leg_nx     = 1'b0;
    end else if (w_run && r_state != S_JUMP) begin
      if (r_leg_cnt == 8'(LEG_DIV - 1)) begin
        w_leg_cnt_nx = '0;
        w_leg_nx     = ~r_leg;
      end else begin
        w_leg_cnt_nx = r_leg_cnt + 8'd1;
      end
    end
  end

  // Parabolic height; derived from registered state so it only moves after a tick.
  logic [11:0] w_tt, w_diff;
  logic [9:0]  w_height;
  assign w_tt          = {5'b0, r_t};
  assign w_diff        = w_tt * 12'(JUMP_T) - w_tt * w_tt;
  assign w_height      = 10'(w_diff >> 1);
  assign o_dino_bottom = 10'(GROUND) - w_height;
  assign o_dino_top    = o_dino_bottom - ((r_state == S_DUCK) ? 10'(DUCK_H) : 10'(SPR_H));
  assign o_state       = r_state;

  always_comb begin
    case (r_state)
      S_JUMP:  o_rom_sel = 2'd2;
      S_DUCK:  o_rom_sel = 2'd3;
      default: o_rom_sel = {1'b0, r_leg};
    endcase
  end

  logic [9:0] w_row, w_drow, w_dcol;
  logic       w_in_box;
  logic       r_in_box, r_px;
  logic [6:0] r_addr_row, r_addr_col;

  assign w_row    = {1'b0, i_row_addr};
  assign w_drow   = w_row - o_dino_top;
  assign w_dcol   = i_col_addr - 10'(X0);
  assign w_in_box = (w_row >= o_dino_top) && (w_row < o_dino_bottom) &&
                    (i_col_addr >= 10'(X0)) && (i_col_addr < 10'(X0 + SPR_W));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_in_box   <= 1'b0;
      r_addr_row <= '0;
      r_addr_col <= '0;
      r_px       <= 1'b0;
    end else begin
      r_in_box   <= w_in_box;
      r_addr_row <= w_in_box ? 7'(w_drow) : 7'd0;
      r_addr_col <= w_in_box ? 7'(w_dcol) : 7'd0;
      r_px       <= r_in_box & i_rom_bit;
    end
  end

  assign o_rom_addr_row = r_addr_row;
  assign o_rom_addr_col = r_addr_col;
  assign o_px           = r_px;

endmodule

// File: tb/tb_dino_motion.sv
// Self-checking bench for dino_motion: directed scenarios with literal
// expectations plus randomized traffic against a behavioural model.
module tb_dino_motion;
  localparam int X0 = 80, GROUND = 402, SPR_W = 82, SPR_H = 88, DUCK_H = 52;
  localparam int JUMP_T = 40, LEG_DIV = 6;

  logic       clk = 1'b0, rst_n = 1'b0;
  logic       frame_tick = 0, game_status = 1, start = 0, button_jump = 0, button_duck = 0;
  logic [8:0] row_addr = '0;
  logic [9:0] col_addr = '0;
  logic       rom_bit = 0;
  logic [6:0] rom_addr_row, rom_addr_col;
  logic [1:0] rom_sel, state;
  logic       px;
  logic [9:0] dino_top, dino_bottom;

  dino_motion dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_frame_tick(frame_tick), .i_game_status(game_status),
    .i_start(start), .i_button_jump(button_jump), .i_button_duck(button_duck),
    .i_row_addr(row_addr), .i_col_addr(col_addr), .o_rom_addr_row(rom_addr_row),
    .o_rom_addr_col(rom_addr_col), .o_rom_sel(rom_sel), .i_rom_bit(rom_bit), .o_px(px),
    .o_dino_top(dino_top), .o_dino_bottom(dino_bottom), .o_state(state));

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      if (errors <= 30) $display("FAIL %s got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: 0 RUN, 1 JUMP, 2 DUCK; t is jump progress in frames.
  int m_st, m_t, m_lc, m_leg, m_inbox, m_rar, m_rac, m_px;

  function automatic int m_bottom();
    return GROUND - (m_t * JUMP_T - m_t * m_t) / 2;
  endfunction
  function automatic int m_top();
    return m_bottom() - ((m_st == 2) ? DUCK_H : SPR_H);
  endfunction
  function automatic int m_sel();
    return (m_st == 1) ? 2 : (m_st == 2) ? 3 : m_leg;
  endfunction

  task automatic model_reset();
    m_st = 0; m_t = 0; m_lc = 0; m_leg = 0;
    m_inbox = 0; m_rar = 0; m_rac = 0; m_px = 0;
  endtask

  task automatic model_update();
    int top, bot, r, c;
    if (!rst_n) return;
    top = m_top(); bot = m_bottom(); r = row_addr; c = col_addr;
    m_px    = m_inbox & int'(rom_bit);
    m_inbox = (r >= top && r < bot && c >= X0 && c < X0 + SPR_W) ? 1 : 0;
    m_rar   = m_inbox ? (r - top) : 0;
    m_rac   = m_inbox ? (c - X0) : 0;
    if (frame_tick && game_status) begin
      if (m_st != 1) begin
        m_lc++;
        if (m_lc == LEG_DIV) begin m_lc = 0; m_leg ^= 1; end
      end
      if (m_st == 0) begin
        if (button_jump) begin m_st = 1; m_t = 1; end
        else if (button_duck) m_st = 2;
      end else if (m_st == 1) begin
        m_t = m_t + (button_duck ? 2 : 1);
        if (m_t >= JUMP_T) begin m_t = 0; m_st = 0; end
      end else if (!button_duck) m_st = 0;
    end else if (frame_tick && start) begin
      m_st = 0; m_t = 0; m_lc = 0; m_leg = 0;
    end
  endtask

  always @(negedge clk) begin
    chk("state", state, m_st);
    chk("dino_top", dino_top, m_top());
    chk("dino_bottom", dino_bottom, m_bottom());
    chk("rom_sel", rom_sel, m_sel());
    chk("rom_addr_row", rom_addr_row, m_rar);
    chk("rom_addr_col", rom_addr_col, m_rac);
    chk("px", px, m_px);
  end

  task automatic cyc();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic tick(input bit gs, input bit st, input bit bj, input bit bd);
    game_status = gs; start = st; button_jump = bj; button_duck = bd;
    frame_tick = 1; cyc();
    frame_tick = 0; cyc();
  endtask

  task automatic do_reset();
    rst_n = 0; model_reset();
    frame_tick = 0; game_status = 1; start = 0; button_jump = 0; button_duck = 0;
    row_addr = '0; col_addr = '0; rom_bit = 0;
    repeat (2) cyc();
    rst_n = 1; cyc();
  endtask

  initial begin
    model_reset();
    #1;
    chk("rst_top", dino_top, 314);
    chk("rst_bottom", dino_bottom, 402);
    chk("rst_px", px, 0);
    do_reset();

    // Full jump, no buttons after the first tick.
    tick(1, 0, 1, 0);
    chk("j1_state", state, 1);
    chk("j1_bottom", dino_bottom, 383);
    repeat (38) tick(1, 0, 0, 0);
    chk("j39_state", state, 1);
    chk("j39_bottom", dino_bottom, 383);
    tick(1, 0, 0, 0);
    chk("j40_state", state, 0);
    chk("j40_bottom", dino_bottom, 402);

    // Apex then fast-fall.
    tick(1, 0, 1, 0);
    repeat (19) tick(1, 0, 0, 0);
    chk("apex_top", dino_top, 114);
    chk("apex_bottom", dino_bottom, 202);
    tick(1, 0, 0, 1);
    chk("ff22_bottom", dino_bottom, 204);
    repeat (8) tick(1, 0, 0, 1);
    chk("ff38_bottom", dino_bottom, 364);
    chk("ff38_state", state, 1);
    tick(1, 0, 0, 1);
    chk("ff_land_state", state, 0);
    chk("ff_land_bottom", dino_bottom, 402);
    tick(1, 0, 0, 0);

    // Jump beats duck; jump ignored while ducking.
    tick(1, 0, 1, 1);
    chk("both_state", state, 1);
    repeat (39) tick(1, 0, 0, 0);
    tick(1, 0, 0, 1);
    chk("duck_state", state, 2);
    chk("duck_top", dino_top, 350);
    tick(1, 0, 1, 1);
    chk("duck_jump_state", state, 2);
    chk("duck_jump_top", dino_top, 350);
    tick(1, 0, 0, 0);
    chk("unduck_state", state, 0);

    // Pause mid-jump, then restart.
    tick(1, 0, 1, 0);
    repeat (9) tick(1, 0, 0, 0);
    chk("t10_bottom", dino_bottom, 252);
    repeat (5) tick(0, 0, 1, 1);
    chk("pause_bottom", dino_bottom, 252);
    chk("pause_state", state, 1);
    tick(0, 1, 0, 0);
    chk("restart_state", state, 0);
    chk("restart_bottom", dino_bottom, 402);
    game_status = 1; start = 0;

    // Pixel pipeline latency and box edge.
    row_addr = 9'd314; col_addr = 10'd80; rom_bit = 0; cyc();
    chk("pix_addr_row", rom_addr_row, 0);
    chk("pix_px_early", px, 0);
    row_addr = 9'd314; col_addr = 10'd161; rom_bit = 1; cyc();
    chk("pix_px", px, 1);
    chk("edge_addr_col", rom_addr_col, 81);
    col_addr = 10'd162; cyc();
    chk("out_addr_col", rom_addr_col, 0);
    rom_bit = 1; cyc();
    chk("out_px", px, 0);
    row_addr = '0; col_addr = '0; rom_bit = 0;

    // Leg animation and async reset mid-jump.
    do_reset();
    repeat (5) tick(1, 0, 0, 0);
    chk("leg5_sel", rom_sel, 0);
    tick(1, 0, 0, 0);
    chk("leg6_sel", rom_sel, 1);
    repeat (5) tick(1, 0, 0, 0);
    chk("leg11_sel", rom_sel, 1);
    tick(1, 0, 0, 0);
    chk("leg12_sel", rom_sel, 0);
    tick(1, 0, 1, 0);
    chk("jump_sel", rom_sel, 2);
    repeat (14) tick(1, 0, 0, 0);
    chk("t15_bottom", dino_bottom, 215);
    row_addr = 9'd150; col_addr = 10'd100; rom_bit = 1;
    repeat (3) cyc();
    chk("t15_px", px, 1);
    rst_n = 0; model_reset();
    #1;
    chk("arst_state", state, 0);
    chk("arst_px", px, 0);
    chk("arst_bottom", dino_bottom, 402);
    do_reset();

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) do_reset();
      frame_tick  = (i % 5 == 0);
      game_status = ($urandom_range(0, 9) != 0);
      start       = ($urandom_range(0, 3) == 0);
      button_jump = ($urandom_range(0, 5) == 0);
      button_duck = ($urandom_range(0, 2) == 0);
      row_addr    = 9'($urandom_range(100, 420));
      col_addr    = 10'($urandom_range(60, 180));
      rom_bit     = 1'($urandom);
      cyc();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/dino_motion.md
DINO_MOTION -- requirements
Module: dino_motion

Interface
REQ-001 Parameter X0, default 80: sprite left column.
REQ-002 Parameter GROUND, default 402: row one below sprite bottom when height is 0.
REQ-003 Parameter SPR_W, default 82: sprite width in pixels.
REQ-004 Parameter SPR_H, default 88: standing/jumping sprite height.
REQ-005 Parameter DUCK_H, default 52: ducking sprite height.
REQ-006 Parameter JUMP_T, default 40: jump duration in frames; must be even.
REQ-007 Parameter LEG_DIV, default 6: frames per leg-animation toggle.
REQ-008 clk  in  1  pixel clock, the only clock; all logic on its rising edge.
REQ-009 rst_n  in  1  asynchronous, active-low reset.
REQ-010 frame_tick  in  1  one-cycle pulse once per frame, in blanking.
REQ-011 game_status  in  1  1 = running, 0 = paused/over.
REQ-012 start  in  1  restart request, honoured only while paused.
REQ-013 button_jump / button_duck  in  1 each  level inputs, already synchronised.
REQ-014 row_addr  in  9;  col_addr  in  10: current scan position.
REQ-015 rom_addr_row  out  7;  rom_addr_col  out  7;  rom_sel  out  2: sprite ROM address (0 run-A, 1 run-B, 2 jump, 3 duck).
REQ-016 rom_bit  in  1  ROM data, valid one clk after address.
REQ-017 px  out  1  dinosaur pixel.
REQ-018 dino_top  out  10;  dino_bottom  out  10: current hitbox rows, for collision logic.
REQ-019 state  out  2: 0 RUN, 1 JUMP, 2 DUCK.

Function
REQ-020 State and jump counter t (7 bit) update only in cycles where frame_tick=1 and game_status=1.
REQ-021 RUN: button_jump=1 -> JUMP, t=1; else button_duck=1 -> DUCK; jump wins when both pressed.
REQ-022 JUMP: t increments by 1 per tick, by 2 if button_duck=1 (fast-fall), saturating at JUMP_T.
REQ-023 JUMP at tick with t reaching or exceeding JUMP_T: t=0, state -> RUN (not DUCK, even if duck held).
REQ-024 DUCK: button_duck=0 -> RUN; button_jump ignored in DUCK.
REQ-025 height = (t*JUMP_T - t*t)/2, unsigned, truncating, computed in 12 bits; 0 when t=0.
REQ-026 Sprite height H = DUCK_H in DUCK, else SPR_H; dino_bottom = GROUND - height; dino_top = dino_bottom - H.
REQ-027 Leg counter counts frame ticks in RUN/DUCK; at LEG_DIV-1 wraps to 0 and toggles leg bit; held in JUMP and while paused.
REQ-028 rom_sel = 2 in JUMP; {leg} in RUN; 3 in DUCK (duck ROM internally uses leg bit via rom_addr_col msb not required).
REQ-029 Stage 1 (registered): in_box = row in [dino_top, dino_bottom) and col in [X0, X0+SPR_W); rom_addr_row = row - dino_top, rom_addr_col = col - X0 (0 when not in_box).
REQ-030 Stage 2 (registered): px = in_box_d1 & rom_bit; total latency from row/col to px is 2 clk.
REQ-031 Paused (game_status=0) and no start: all motion state frozen; px keeps rendering frozen position.
REQ-032 Paused and start=1 on a frame tick: t=0, state RUN, leg counter 0, leg bit 0.
REQ-033 frame_tick with game_status=1 ignores start.
REQ-034 Changes of dino_top/dino_bottom occur only in the cycle after frame_tick, never mid-frame.

Reset
REQ-035 rst_n=0 asynchronously forces: state RUN, t=0, leg counter 0, leg bit 0, in_box pipeline 0, px=0, rom_addr_row/col 0, rom_sel 0.
REQ-036 After reset dino_top = GROUND - SPR_H (314 default), dino_bottom = GROUND (402).
REQ-037 Reset asserted mid-jump aborts the jump; release returns to RUN on the ground with no further tick needed.

Verification
REQ-038 Reset, game_status=1, press jump one tick, release -> state JUMP, t=1, dino_bottom=383 (height 19); after 40 ticks total state RUN, dino_bottom=402.
REQ-039 Jump to t=20 -> height 200, dino_top=114, dino_bottom=202; hold duck from t=20 -> t 22,24,..., land after 10 more ticks.
REQ-040 RUN, jump and duck pressed same tick -> JUMP; in DUCK press jump -> stays DUCK, dino_top=350.
REQ-041 Mid-jump at t=10 set game_status=0 for 5 ticks -> t stays 10, dino_bottom=252; pulse start on tick -> t=0, RUN, dino_bottom=402.
REQ-042 Scan row 314, col 80 with rom_bit=1 one clk later -> px=1 exactly 2 clk after address; col 162 -> px=0, rom_addr_col=0.
REQ-043 RUN 12 ticks with LEG_DIV=6 -> rom_sel 0 -> 1 at tick 6 -> 0 at tick 12; assert rst_n=0 at t=15 -> px=0, state RUN immediately.
